// File: rtl/tomasulo_pkg.sv
// Shared decode definitions for the issue/rename slice: opcode classes, ROB entry layout, opcode decode.
// Latency: none (types and a pure function only).
// Backpressure: n/a.
package tomasulo_pkg;

    typedef enum logic [1:0] {
        CLS_ADD  = 2'd0,
        CLS_MUL  = 2'd1,
        CLS_BR   = 2'd2,
        CLS_NONE = 2'd3
    } op_class_e;

    // ROB entries are stored at fixed maximum field widths so the struct can live in the package;
    // the parameterised top zero-extends into and truncates out of these fields.
    localparam int ROB_FUNC_W = 8;
    localparam int ROB_RD_W   = 6;

    typedef struct packed {
        logic [ROB_FUNC_W-1:0] func;
        logic [ROB_RD_W-1:0]   rd;
        op_class_e             cls;
    } rob_entry_t;

    // 0000/0001 ADD, 0010/0011 MUL, 0100..0111 BR, everything else illegal.
    function automatic op_class_e decode_class(input logic [ROB_FUNC_W-1:0] f);
        op_class_e c;
        case (f)
            8'h00, 8'h01:               c = CLS_ADD;
            8'h02, 8'h03:               c = CLS_MUL;
            8'h04, 8'h05, 8'h06, 8'h07: c = CLS_BR;
            default:                    c = CLS_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/issue_rename_unit_if.sv
// Bundle of the issue/rename unit's instruction, issue-packet and control signals.
// Latency: none (wiring only).
// Backpressure: master offers in_valid, slave answers in_ready; the issue packet has no ready.
interface issue_rename_unit_if #(
    parameter int NREG      = 16,
    parameter int ROB_DEPTH = 8,
    parameter int FUNC_W    = 4
);
    localparam int REG_W = $clog2(NREG);
    localparam int TAG_W = $clog2(ROB_DEPTH);

    logic              in_valid;
    logic              in_ready;
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;

    logic              out_valid;
    logic [1:0]        out_class;
    logic [FUNC_W-1:0] out_func;
    logic [REG_W-1:0]  out_rd;
    logic [TAG_W-1:0]  out_rob_idx;
    logic              out_rs1_busy;
    logic              out_rs2_busy;
    logic [TAG_W-1:0]  out_rs1_tag;
    logic [TAG_W-1:0]  out_rs2_tag;

    logic [2:0]        rs_release;
    logic              commit_valid;
    logic              flush;
    logic              err_illegal;
    logic [TAG_W:0]    rob_count;

    modport master (
        output in_valid, func, rs1, rs2, rd, rs_release, commit_valid, flush,
        input  in_ready, out_valid, out_class, out_func, out_rd, out_rob_idx,
               out_rs1_busy, out_rs2_busy, out_rs1_tag, out_rs2_tag, err_illegal, rob_count
    );

    modport slave (
        input  in_valid, func, rs1, rs2, rd, rs_release, commit_valid, flush,
        output in_ready, out_valid, out_class, out_func, out_rd, out_rob_idx,
               out_rs1_busy, out_rs2_busy, out_rs1_tag, out_rs2_tag, err_illegal, rob_count
    );
endinterface

// File: rtl/rename_table.sv
// Register alias table: per architectural register a busy bit and the ROB tag of its newest producer.
// Latency: reads combinational, write/clear take effect at the next clk1 edge.
// Backpressure: none; clr_all beats wr_en beats the conditional clear.
// Ports: clk1/rst_n; two read ports (rd_idx -> rd_busy, rd_tag); one write port (wr_en, wr_idx, wr_tag);
//        conditional clear (clr_en, clr_idx, clr_tag: clears busy only if the stored tag matches); clr_all.
module rename_table #(
    parameter int NREG  = 16,
    parameter int TAG_W = 3
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    input  logic [$clog2(NREG)-1:0]  rd_idx1,
    output logic                     rd_busy1,
    output logic [TAG_W-1:0]         rd_tag1,
    input  logic [$clog2(NREG)-1:0]  rd_idx2,
    output logic                     rd_busy2,
    output logic [TAG_W-1:0]         rd_tag2,
    input  logic                     wr_en,
    input  logic [$clog2(NREG)-1:0]  wr_idx,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic                     clr_en,
    input  logic [$clog2(NREG)-1:0]  clr_idx,
    input  logic [TAG_W-1:0]         clr_tag,
    input  logic                     clr_all
);
    localparam int REG_W = $clog2(NREG);

    logic [NREG-1:0]  busy_q;
    logic [TAG_W-1:0] tag_q [NREG];

    assign rd_busy1 = busy_q[rd_idx1];
    assign rd_tag1  = tag_q[rd_idx1];
    assign rd_busy2 = busy_q[rd_idx2];
    assign rd_tag2  = tag_q[rd_idx2];

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++) tag_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (clr_all) begin
                    busy_q[i] <= 1'b0;
                end else if (wr_en && wr_idx == REG_W'(i)) begin
                    // A new rename of the same register wins over the retiring producer's clear.
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= wr_tag;
                end else if (clr_en && clr_idx == REG_W'(i) && tag_q[i] == clr_tag) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/issue_rename_unit.sv
// Decodes, renames and allocates a ROB entry per instruction, emitting a registered issue packet.
// Latency: 1 cycle from accept to out_valid / err_illegal.
// Backpressure: in_ready drops when flushing, the ROB is full, or the decoded class has no free RS slot.
// Ports: clk1, rst_n (async active-low); bus (slave): instruction in, issue packet out,
//        rs_release/commit_valid/flush control, err_illegal and rob_count status.
module issue_rename_unit
    import tomasulo_pkg::*;
#(
    parameter int NREG         = 16,
    parameter int ROB_DEPTH    = 8,
    parameter int RS_PER_CLASS = 3,
    parameter int FUNC_W       = 4
) (
    input  logic clk1,
    input  logic rst_n,
    issue_rename_unit_if.slave bus
);
    localparam int REG_W = $clog2(NREG);
    localparam int TAG_W = $clog2(ROB_DEPTH);
    localparam int CNT_W = $clog2(RS_PER_CLASS + 1);
    localparam logic [CNT_W-1:0] RS_MAX   = CNT_W'(RS_PER_CLASS);
    localparam logic [TAG_W:0]   ROB_FULL = (TAG_W + 1)'(ROB_DEPTH);

    rob_entry_t       rob_q [ROB_DEPTH];
    logic [TAG_W-1:0] head_q, tail_q;
    logic [TAG_W:0]   count_q;
    logic [CNT_W-1:0] rs_cnt_q [3];

    op_class_e        dec_cls;
    logic             legal, rs_room, acc, legal_acc, illegal_acc, commit_fire;
    logic [2:0]       rs_inc;
    logic             rat_busy1, rat_busy2;
    logic [TAG_W-1:0] rat_tag1, rat_tag2;
    rob_entry_t       head_ent;

    assign dec_cls = decode_class(ROB_FUNC_W'(bus.func));
    assign legal   = (dec_cls != CLS_NONE);

    always_comb begin
        rs_room = 1'b0;
        case (dec_cls)
            CLS_ADD: rs_room = (rs_cnt_q[0] < RS_MAX);
            CLS_MUL: rs_room = (rs_cnt_q[1] < RS_MAX);
            CLS_BR:  rs_room = (rs_cnt_q[2] < RS_MAX);
            default: rs_room = 1'b0;
        endcase
    end

    // Illegal opcodes are always accepted (they only raise err_illegal), so they skip ROB/RS checks.
    assign bus.in_ready = !bus.flush && (!legal || (count_q != ROB_FULL && rs_room));
    assign acc          = bus.in_valid && bus.in_ready;
    assign legal_acc    = acc && legal;
    assign illegal_acc  = acc && !legal;
    assign commit_fire  = bus.commit_valid && (count_q != '0) && !bus.flush;
    assign head_ent     = rob_q[head_q];

    always_comb begin
        for (int c = 0; c < 3; c++) rs_inc[c] = legal_acc && (2'(dec_cls) == 2'(c));
    end

    rename_table #(.NREG(NREG), .TAG_W(TAG_W)) u_rat (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .rd_idx1  (bus.rs1),
        .rd_busy1 (rat_busy1),
        .rd_tag1  (rat_tag1),
        .rd_idx2  (bus.rs2),
        .rd_busy2 (rat_busy2),
        .rd_tag2  (rat_tag2),
        .wr_en    (legal_acc && dec_cls != CLS_BR),
        .wr_idx   (bus.rd),
        .wr_tag   (tail_q),
        .clr_en   (commit_fire && head_ent.cls != CLS_BR),
        .clr_idx  (head_ent.rd[REG_W-1:0]),
        .clr_tag  (head_q),
        .clr_all  (bus.flush)
    );

    // Entry payload needs no reset: it is only read while counted as occupied.
    always_ff @(posedge clk1) begin
        if (legal_acc) rob_q[tail_q] <= '{func: ROB_FUNC_W'(bus.func), rd: ROB_RD_W'(bus.rd), cls: dec_cls};
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int c = 0; c < 3; c++) rs_cnt_q[c] <= '0;
        end else if (bus.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int c = 0; c < 3; c++) rs_cnt_q[c] <= '0;
        end else begin
            if (legal_acc)   tail_q <= tail_q + TAG_W'(1);
            if (commit_fire) head_q <= head_q + TAG_W'(1);
            count_q <= count_q + {{TAG_W{1'b0}}, legal_acc} - {{TAG_W{1'b0}}, commit_fire};
            for (int c = 0; c < 3; c++) begin
                if (rs_inc[c] && bus.rs_release[c]) rs_cnt_q[c] <= rs_cnt_q[c];
                else if (rs_inc[c])                  rs_cnt_q[c] <= rs_cnt_q[c] + CNT_W'(1);
                else if (bus.rs_release[c] && rs_cnt_q[c] != '0)
                                                     rs_cnt_q[c] <= rs_cnt_q[c] - CNT_W'(1);
            end
        end
    end

    // Issue packet register. Source busy is masked when the producer retires in this same cycle.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.err_illegal  <= 1'b0;
            bus.out_class    <= '0;
            bus.out_func     <= '0;
            bus.out_rd       <= '0;
            bus.out_rob_idx  <= '0;
            bus.out_rs1_busy <= 1'b0;
            bus.out_rs2_busy <= 1'b0;
            bus.out_rs1_tag  <= '0;
            bus.out_rs2_tag  <= '0;
        end else if (bus.flush) begin
            bus.out_valid   <= 1'b0;
            bus.err_illegal <= 1'b0;
        end else begin
            bus.out_valid   <= legal_acc;
            bus.err_illegal <= illegal_acc;
            if (legal_acc) begin
                bus.out_class    <= 2'(dec_cls);
                bus.out_func     <= bus.func;
                bus.out_rd       <= bus.rd;
                bus.out_rob_idx  <= tail_q;
                bus.out_rs1_busy <= rat_busy1 && !(commit_fire && rat_tag1 == head_q);
                bus.out_rs2_busy <= rat_busy2 && !(commit_fire && rat_tag2 == head_q);
                bus.out_rs1_tag  <= rat_tag1;
                bus.out_rs2_tag  <= rat_tag2;
            end
        end
    end

    assign bus.rob_count = count_q;
endmodule

// File: tb/tb_issue_rename_unit.sv
`timescale 1ns/1ps
module tb_issue_rename_unit;
    localparam int NREG = 16, ROB_DEPTH = 8, RS_PER_CLASS = 3, FUNC_W = 4;

    logic clk1 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk1 = ~clk1;

    issue_rename_unit_if #(.NREG(NREG), .ROB_DEPTH(ROB_DEPTH), .FUNC_W(FUNC_W)) bus ();

    issue_rename_unit #(.NREG(NREG), .ROB_DEPTH(ROB_DEPTH), .RS_PER_CLASS(RS_PER_CLASS), .FUNC_W(FUNC_W)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: ROB as a queue of {rd, class}, RAT as plain arrays, RS occupancy as integers.
    typedef struct { int rd; int cls; } ent_t;
    ent_t rob_m[$];
    int   m_head, m_tail;
    bit   m_busy [NREG];
    int   m_tag  [NREG];
    int   m_rs   [3];

    logic       e_valid, e_err, e_b1, e_b2;
    logic [1:0] e_class;
    logic [3:0] e_func, e_rd;
    logic [2:0] e_idx, e_t1, e_t2;

    function automatic int cls_of(input int f);
        if (f <= 1) return 0;
        if (f <= 3) return 1;
        if (f <= 7) return 2;
        return -1;
    endfunction

    function automatic bit m_ready();
        int c;
        c = cls_of(int'(bus.func));
        if (bus.flush) return 1'b0;
        if (c < 0) return 1'b1;
        return (rob_m.size() < ROB_DEPTH) && (m_rs[c] < RS_PER_CLASS);
    endfunction

    task automatic m_reset();
        rob_m.delete();
        m_head = 0; m_tail = 0;
        for (int i = 0; i < NREG; i++) begin m_busy[i] = 1'b0; m_tag[i] = 0; end
        for (int k = 0; k < 3; k++) m_rs[k] = 0;
        e_valid = 0; e_err = 0; e_b1 = 0; e_b2 = 0;
        e_class = 0; e_func = 0; e_rd = 0; e_idx = 0; e_t1 = 0; e_t2 = 0;
    endtask

    task automatic drive(input bit v, input int f, input int r1, input int r2, input int d,
                         input int rel, input bit cm, input bit fl);
        bus.in_valid = v; bus.func = 4'(f); bus.rs1 = 4'(r1); bus.rs2 = 4'(r2); bus.rd = 4'(d);
        bus.rs_release = 3'(rel); bus.commit_valid = cm; bus.flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance the model by one edge using the currently driven inputs, then clock the DUT.
    task automatic tick();
        int c, f, r1, r2, d;
        bit acc, cm, inc, rel;
        ent_t h;
        f = int'(bus.func); c = cls_of(f);
        r1 = int'(bus.rs1); r2 = int'(bus.rs2); d = int'(bus.rd);
        acc = bus.in_valid && m_ready();
        cm  = bus.commit_valid && rob_m.size() > 0 && !bus.flush;
        if (bus.flush) begin
            rob_m.delete(); m_head = 0; m_tail = 0;
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            for (int k = 0; k < 3; k++) m_rs[k] = 0;
            e_valid = 0; e_err = 0;
        end else begin
            e_valid = acc && c >= 0;
            e_err   = acc && c < 0;
            if (e_valid) begin
                e_class = 2'(c); e_func = 4'(f); e_rd = 4'(d); e_idx = 3'(m_tail);
                e_b1 = m_busy[r1] && !(cm && m_tag[r1] == m_head); e_t1 = 3'(m_tag[r1]);
                e_b2 = m_busy[r2] && !(cm && m_tag[r2] == m_head); e_t2 = 3'(m_tag[r2]);
            end
            if (cm) begin
                h = rob_m.pop_front();
                if (h.cls != 2 && m_busy[h.rd] && m_tag[h.rd] == m_head) m_busy[h.rd] = 1'b0;
                m_head = (m_head + 1) % ROB_DEPTH;
            end
            if (e_valid) begin
                rob_m.push_back('{rd: d, cls: c});
                if (c != 2) begin m_busy[d] = 1'b1; m_tag[d] = m_tail; end
                m_tail = (m_tail + 1) % ROB_DEPTH;
            end
            for (int k = 0; k < 3; k++) begin
                inc = e_valid && c == k; rel = bus.rs_release[k];
                if (inc && rel) m_rs[k] = m_rs[k];
                else if (inc) m_rs[k]++;
                else if (rel && m_rs[k] > 0) m_rs[k]--;
            end
        end
        @(posedge clk1); #1;
    endtask

    task automatic test_reset();
        idle(); rst_n = 1'b0; m_reset();
        repeat (2) @(posedge clk1); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0d exp=0", bus.out_valid); end
        checks++; if (bus.err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err got=%0d exp=0", bus.err_illegal); end
        checks++; if (bus.rob_count !== 4'd0) begin errors++; $display("FAIL reset_rob_count got=%0d exp=0", bus.rob_count); end
        checks++; if (bus.out_rob_idx !== 3'd0) begin errors++; $display("FAIL reset_rob_idx got=%0d exp=0", bus.out_rob_idx); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0d exp=1", bus.in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        drive(1, 0, 2, 3, 1, 0, 0, 0); #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got=%0d exp=1", bus.in_ready); end
        tick(); idle();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0d exp=1", bus.out_valid); end
        checks++; if (bus.out_rob_idx !== 3'd0) begin errors++; $display("FAIL basic_rob_idx got=%0d exp=0", bus.out_rob_idx); end
        checks++; if (bus.out_rs1_busy !== 1'b0 || bus.out_rs2_busy !== 1'b0) begin errors++; $display("FAIL basic_src_busy got=%0d/%0d exp=0/0", bus.out_rs1_busy, bus.out_rs2_busy); end
        checks++; if (bus.out_class !== 2'd0 || bus.out_rd !== 4'd1) begin errors++; $display("FAIL basic_class_rd got=%0d/%0d exp=0/1", bus.out_class, bus.out_rd); end
        checks++; if (bus.rob_count !== 4'd1) begin errors++; $display("FAIL basic_rob_count got=%0d exp=1", bus.rob_count); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%0d exp=0", bus.out_valid); end
    endtask

    task automatic test_dependency();
        drive(1, 2, 1, 5, 4, 0, 0, 0); tick(); idle();
        checks++; if (bus.out_rs1_busy !== 1'b1 || bus.out_rs1_tag !== 3'd0) begin errors++; $display("FAIL dep_rs1 got=busy%0d tag%0d exp=busy1 tag0", bus.out_rs1_busy, bus.out_rs1_tag); end
        checks++; if (bus.out_rob_idx !== 3'd1 || bus.out_class !== 2'd1) begin errors++; $display("FAIL dep_idx_class got=%0d/%0d exp=1/1", bus.out_rob_idx, bus.out_class); end
        checks++; if (bus.out_rs2_busy !== 1'b0) begin errors++; $display("FAIL dep_rs2 got=%0d exp=0", bus.out_rs2_busy); end
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick(); idle();
        checks++; if (bus.rob_count !== 4'd0) begin errors++; $display("FAIL dep_flush_count got=%0d exp=0", bus.rob_count); end
    endtask

    task automatic test_rob_full();
        int fs [3];
        fs[0] = 0; fs[1] = 2; fs[2] = 4;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            drive(1, fs[i % 3], 0, 0, i + 1, 1 << (i % 3), 0, 0); tick();
        end
        drive(1, 0, 0, 0, 9, 0, 0, 0); #1;
        checks++; if (bus.rob_count !== 4'd8) begin errors++; $display("FAIL full_count got=%0d exp=8", bus.rob_count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%0d exp=0", bus.in_ready); end
        drive(1, 0, 0, 0, 9, 0, 1, 0); #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_commit_nobypass got=%0d exp=0", bus.in_ready); end
        tick(); drive(1, 0, 0, 0, 9, 0, 0, 0); #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.rob_count !== 4'd7) begin errors++; $display("FAIL full_after_commit got=rdy%0d cnt%0d exp=rdy1 cnt7", bus.in_ready, bus.rob_count); end
        tick(); idle();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_rob_idx !== 3'd0) begin errors++; $display("FAIL full_wrap got=v%0d idx%0d exp=v1 idx0", bus.out_valid, bus.out_rob_idx); end
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick(); idle();
    endtask

    task automatic test_rs_full();
        for (int i = 0; i < 3; i++) begin drive(1, 0, 0, 0, i + 1, 0, 0, 0); tick(); end
        drive(1, 1, 0, 0, 5, 0, 0, 0); #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rs_add_blocked got=%0d exp=0", bus.in_ready); end
        drive(1, 2, 0, 0, 5, 0, 0, 0); #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rs_mul_open got=%0d exp=1", bus.in_ready); end
        drive(1, 0, 0, 0, 5, 1, 0, 0); #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rs_release_nobypass got=%0d exp=0", bus.in_ready); end
        tick(); drive(1, 0, 0, 0, 5, 0, 0, 0); #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rs_after_release got=%0d exp=1", bus.in_ready); end
        tick(); idle();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_rob_idx !== 3'd3) begin errors++; $display("FAIL rs_accept got=v%0d idx%0d exp=v1 idx3", bus.out_valid, bus.out_rob_idx); end
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick(); idle();
    endtask

    task automatic test_commit_bypass();
        drive(1, 0, 0, 0, 1, 0, 0, 0); tick();
        drive(1, 2, 1, 0, 6, 0, 1, 0); tick();
        checks++; if (bus.out_rs1_busy !== 1'b0 || bus.out_rob_idx !== 3'd1) begin errors++; $display("FAIL byp_commit_src got=busy%0d idx%0d exp=busy0 idx1", bus.out_rs1_busy, bus.out_rob_idx); end
        drive(1, 1, 6, 0, 6, 0, 1, 0); tick();
        checks++; if (bus.out_rs1_busy !== 1'b0 || bus.out_rob_idx !== 3'd2) begin errors++; $display("FAIL byp_same_rd_src got=busy%0d idx%0d exp=busy0 idx2", bus.out_rs1_busy, bus.out_rob_idx); end
        drive(1, 3, 6, 0, 7, 0, 0, 0); tick(); idle();
        checks++; if (bus.out_rs1_busy !== 1'b1 || bus.out_rs1_tag !== 3'd2) begin errors++; $display("FAIL byp_rename_wins got=busy%0d tag%0d exp=busy1 tag2", bus.out_rs1_busy, bus.out_rs1_tag); end
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick(); idle();
    endtask

    task automatic test_illegal_flush();
        drive(1, 0, 0, 0, 1, 0, 0, 0); tick();
        drive(1, 2, 0, 0, 2, 0, 0, 0); tick();
        drive(1, 10, 0, 0, 3, 0, 0, 0); #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ill_in_ready got=%0d exp=1", bus.in_ready); end
        tick(); idle();
        checks++; if (bus.err_illegal !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL ill_pulse got=err%0d v%0d exp=err1 v0", bus.err_illegal, bus.out_valid); end
        checks++; if (bus.rob_count !== 4'd2) begin errors++; $display("FAIL ill_count got=%0d exp=2", bus.rob_count); end
        tick();
        checks++; if (bus.err_illegal !== 1'b0) begin errors++; $display("FAIL ill_pulse_len got=%0d exp=0", bus.err_illegal); end
        drive(1, 1, 0, 0, 3, 0, 0, 0); tick();
        drive(1, 3, 0, 0, 4, 0, 0, 0); tick();
        drive(1, 5, 0, 0, 5, 0, 0, 0); tick();
        checks++; if (bus.rob_count !== 4'd5) begin errors++; $display("FAIL ill_five got=%0d exp=5", bus.rob_count); end
        drive(1, 0, 0, 0, 9, 0, 1, 1); #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%0d exp=0", bus.in_ready); end
        tick(); idle();
        checks++; if (bus.rob_count !== 4'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_state got=cnt%0d v%0d exp=cnt0 v0", bus.rob_count, bus.out_valid); end
        drive(1, 0, 1, 2, 7, 0, 0, 0); tick();
        checks++; if (bus.out_rob_idx !== 3'd0 || bus.out_rs1_busy !== 1'b0 || bus.out_rs2_busy !== 1'b0) begin errors++; $display("FAIL flush_next got=idx%0d b%0d%0d exp=idx0 b00", bus.out_rob_idx, bus.out_rs1_busy, bus.out_rs2_busy); end
        drive(1, 0, 3, 4, 8, 0, 0, 0); tick(); idle();
        checks++; if (bus.out_rs1_busy !== 1'b0 || bus.out_rs2_busy !== 1'b0) begin errors++; $display("FAIL flush_rat_clear got=b%0d%0d exp=b00", bus.out_rs1_busy, bus.out_rs2_busy); end
    endtask

    task automatic test_reset_midop();
        drive(1, 0, 0, 0, 2, 0, 0, 0); tick(); idle();
        #2 rst_n = 1'b0; #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.rob_count !== 4'd0) begin errors++; $display("FAIL arst_clear got=v%0d cnt%0d exp=v0 cnt0", bus.out_valid, bus.rob_count); end
        @(posedge clk1); #1; rst_n = 1'b1; m_reset();
        drive(1, 2, 2, 0, 3, 0, 0, 0); tick(); idle();
        checks++; if (bus.out_rob_idx !== 3'd0 || bus.out_rs1_busy !== 1'b0) begin errors++; $display("FAIL arst_first got=idx%0d b%0d exp=idx0 b0", bus.out_rob_idx, bus.out_rs1_busy); end
        tick();
    endtask

    task automatic test_random();
        int f;
        for (int n = 0; n < 600; n++) begin
            f = ($urandom % 8 == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
            drive($urandom % 4 != 0, f, $urandom % 16, $urandom % 16, $urandom % 16,
                  ($urandom % 3 == 0) ? int'($urandom % 8) : 0, $urandom % 3 == 0, $urandom % 50 == 0);
            #1;
            checks++; if (bus.in_ready !== m_ready()) begin errors++; $display("FAIL rnd_in_ready n=%0d got=%0d exp=%0d", n, bus.in_ready, m_ready()); end
            tick();
            checks++; if (bus.out_valid !== e_valid || bus.err_illegal !== e_err) begin errors++; $display("FAIL rnd_valid_err n=%0d got=%0d/%0d exp=%0d/%0d", n, bus.out_valid, bus.err_illegal, e_valid, e_err); end
            checks++; if (bus.rob_count !== 4'(rob_m.size())) begin errors++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, bus.rob_count, rob_m.size()); end
            if (e_valid) begin
                checks++; if (bus.out_class !== e_class || bus.out_func !== e_func || bus.out_rd !== e_rd || bus.out_rob_idx !== e_idx) begin
                    errors++; $display("FAIL rnd_packet n=%0d got=c%0d f%0d rd%0d idx%0d exp=c%0d f%0d rd%0d idx%0d", n, bus.out_class, bus.out_func, bus.out_rd, bus.out_rob_idx, e_class, e_func, e_rd, e_idx); end
                checks++; if (bus.out_rs1_busy !== e_b1 || (e_b1 && bus.out_rs1_tag !== e_t1)) begin errors++; $display("FAIL rnd_rs1 n=%0d got=b%0d t%0d exp=b%0d t%0d", n, bus.out_rs1_busy, bus.out_rs1_tag, e_b1, e_t1); end
                checks++; if (bus.out_rs2_busy !== e_b2 || (e_b2 && bus.out_rs2_tag !== e_t2)) begin errors++; $display("FAIL rnd_rs2 n=%0d got=b%0d t%0d exp=b%0d t%0d", n, bus.out_rs2_busy, bus.out_rs2_tag, e_b2, e_t2); end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        m_reset();
        test_reset();
        test_basic();
        test_dependency();
        test_rob_full();
        test_rs_full();
        test_commit_bypass();
        test_illegal_flush();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/issue_rename_unit.md
ISSUE_RENAME_UNIT -- requirements
Module: issue_rename_unit

Interface
REQ-001 Parameters SHALL be: NREG, default 16, architectural register count; ROB_DEPTH, default 8, ROB entries (power of 2); RS_PER_CLASS, default 3, RS slots per class; FUNC_W, default 4, opcode width.
REQ-002 One clock; reset is asynchronous and active-low: clk1 in 1, rising-edge clock; rst_n in 1, async active-low reset.
REQ-003 Ports SHALL be: in_valid in 1, instruction offered; in_ready out 1, accept possible; func in FUNC_W, opcode; rs1, rs2, rd in log2(NREG) each, register fields.
REQ-004 Ports SHALL be: out_valid out 1, issue packet valid; out_class out 2, 0=ADD 1=MUL 2=BR; out_func out FUNC_W; out_rd out log2(NREG); out_rob_idx out log2(ROB_DEPTH), allocated tag.
REQ-005 Ports SHALL be: out_rs1_busy, out_rs2_busy out 1 each, operand pending; out_rs1_tag, out_rs2_tag out log2(ROB_DEPTH) each, producer tag.
REQ-006 Ports SHALL be: rs_release in 3, one-hot-per-class slot free; commit_valid in 1, retire ROB head; flush in 1, squash all; err_illegal out 1, illegal-opcode pulse; rob_count out log2(ROB_DEPTH)+1, occupancy.

Function
REQ-007 Decode: func 0000/0001 -> ADD, 0010/0011 -> MUL, 0100-0111 -> BR; all other values illegal.
REQ-008 in_ready SHALL be 1 iff flush=0, rob_count<ROB_DEPTH, and the decoded class RS count<RS_PER_CLASS; illegal opcodes ignore ROB/RS terms.
REQ-009 Accept = in_valid & in_ready; legal accept allocates ROB[tail] (func, rd, class), increments tail mod ROB_DEPTH, rob_count, and class RS count.
REQ-010 Full SHALL be rob_count==ROB_DEPTH; all ROB_DEPTH entries usable (no one-slot reservation).
REQ-011 ADD/MUL accept SHALL set RAT[rd]={busy=1, tag=tail}; BR accept SHALL not modify RAT.
REQ-012 Source lookup SHALL use RAT state before this instruction's rename (rs1==rd sees older producer).
REQ-013 Source lookup SHALL report busy=0 when the RAT tag equals the ROB entry committing in the same cycle.
REQ-014 Issue packet SHALL be registered: out_valid=1 exactly one cycle after each legal accept, else 0.
REQ-015 Illegal accept SHALL pulse err_illegal for one cycle (registered, same latency as out_valid) with no allocation and out_valid=0.
REQ-016 commit_valid with rob_count>0 SHALL pop head; if RAT[ROB[head].rd] busy with tag==head and entry not BR, clear busy. commit_valid with rob_count==0 ignored.
REQ-017 Same-cycle accept and commit: rob_count unchanged net; if both touch same RAT rd, the accept's rename wins.
REQ-018 rs_release[c] SHALL decrement class c count if nonzero (saturate at 0); simultaneous release and accept on c leaves count unchanged.
REQ-019 in_ready SHALL use registered counts only; same-cycle commit/release does not bypass into in_ready.
REQ-020 flush SHALL, next edge, reset head, tail, rob_count, RS counts, all RAT busy bits, out_valid, err_illegal to 0; flush overrides accept, commit, release.

Reset
REQ-021 rst_n=0 SHALL asynchronously clear head, tail, rob_count, RS counts, RAT busy/tag, out_valid, err_illegal, all out_* fields to 0; in_ready evaluates from cleared state.
REQ-022 Reset asserted mid-operation SHALL discard in-flight packet; first accept after release gets out_rob_idx 0.

Structure
REQ-023 Opcode encodings, class codes, and ROB entry struct SHALL live in shared package tomasulo_pkg.
REQ-024 RAT SHALL be sub-module rename_table (NREG entries, read 2 ports, write 1 port, conditional clear port).
REQ-025 Target size 120-400 RTL lines; no latches; all storage in clk1 domain.

Verification
REQ-026 Reset, issue ADD r1=r2+r3 (func 0000, rd=1) -> next cycle out_valid=1, out_rob_idx=0, rs1/rs2 busy=0; RAT[1]={1,0}.
REQ-027 Issue ADD rd=1 then MUL rs1=1 rd=4 -> MUL packet out_rs1_busy=1, out_rs1_tag=0, out_rob_idx=1.
REQ-028 Issue 8 legal ops without commit (rotating classes, releases given) -> rob_count=8, in_ready=0; commit once -> in_ready=1 next cycle; 9th gets tag 0 (wrap).
REQ-029 Issue 3 ADDs without release -> 4th ADD in_ready=0 while MUL in_ready=1; rs_release=001 -> ADD accepted next cycle.
REQ-030 Commit tag 0 in same cycle MUL reads rs1 mapped to tag 0 -> out_rs1_busy=0; same-cycle issue renaming committed rd -> RAT holds new tag.
REQ-031 func 1010 -> err_illegal pulse, rob_count unchanged; flush with 5 entries -> rob_count=0, all RAT busy=0, next tag 0.
